// File: rtl/ensemble_vote_combiner_if.sv
`default_nettype none
// ============================================================================
// Module      : ensemble_vote_combiner_if
// Description : AXI-Stream bundle (data, keep, valid, ready, last) shared by
//               the three classifier inputs and the voted output.
// Revision    : 1.0 - initial release
// ============================================================================
interface ensemble_vote_combiner_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ensemble_vote_combiner.sv
`default_nettype none
// ============================================================================
// Module      : ensemble_vote_combiner
// Description : Collects one prediction beat from each of three classifier
//               streams, majority-votes the labels and emits a single result
//               beat {count, label}. Tracks sample / disagreement counts and a
//               sticky tlast-mismatch flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ensemble_vote_combiner #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int LABEL_WIDTH = 8,
  parameter int TIE_SRC     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ensemble_vote_combiner_if.slave         s_axis_0,
  ensemble_vote_combiner_if.slave         s_axis_1,
  ensemble_vote_combiner_if.slave         s_axis_2,
  ensemble_vote_combiner_if.master        m_axis,
  output logic [31:0]                     sample_count,
  output logic [31:0]                     disagree_count,
  output logic                            err_tlast_mismatch
);

  // rst_n is expected to be released synchronously to clk by the wrapper.

  // --------------------------------------------------------------------------
  // Input gathering
  // --------------------------------------------------------------------------
  logic [LABEL_WIDTH-1:0] w_in_label [3];
  logic [2:0]             w_in_valid;
  logic [2:0]             w_in_last;

  assign w_in_label[0] = s_axis_0.tdata[LABEL_WIDTH-1:0];
  assign w_in_label[1] = s_axis_1.tdata[LABEL_WIDTH-1:0];
  assign w_in_label[2] = s_axis_2.tdata[LABEL_WIDTH-1:0];
  assign w_in_valid    = {s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
  assign w_in_last     = {s_axis_2.tlast,  s_axis_1.tlast,  s_axis_0.tlast};

  // Keep and the bits above the label carry nothing the vote uses.
  logic w_unused_bits;
  assign w_unused_bits = ^{s_axis_0.tkeep, s_axis_1.tkeep, s_axis_2.tkeep,
                           s_axis_0.tdata[DATA_WIDTH-1:LABEL_WIDTH],
                           s_axis_1.tdata[DATA_WIDTH-1:LABEL_WIDTH],
                           s_axis_2.tdata[DATA_WIDTH-1:LABEL_WIDTH]};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]             held_q, held_d;
  logic [LABEL_WIDTH-1:0] label_q [3];
  logic [LABEL_WIDTH-1:0] label_d [3];
  logic [2:0]             last_q, last_d;

  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q,  m_data_d;
  logic [KEEP_WIDTH-1:0]  m_keep_q,  m_keep_d;
  logic                   m_last_q,  m_last_d;
  logic [31:0]            sample_q,  sample_d;
  logic [31:0]            disagree_q, disagree_d;
  logic                   err_q,     err_d;

  // Ready depends only on the hold flags, never on any valid or on m tready.
  assign s_axis_0.tready = ~held_q[0];
  assign s_axis_1.tready = ~held_q[1];
  assign s_axis_2.tready = ~held_q[2];

  // The vote needs all three beats and a free (or draining) output register.
  logic w_fire;
  assign w_fire = (&held_q) & (~m_valid_q | m_axis.tready);

  // Capture each stream's beat into its slot; a vote frees all three slots.
  always_comb begin
    held_d = held_q;
    last_d = last_q;
    for (int k = 0; k < 3; k++) begin
      label_d[k] = label_q[k];
      if (w_fire) begin
        held_d[k] = 1'b0;
      end else if (w_in_valid[k] && !held_q[k]) begin
        held_d[k]  = 1'b1;
        label_d[k] = w_in_label[k];
        last_d[k]  = w_in_last[k];
      end
    end
  end

  // Hold-slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      last_q <= '0;
      for (int k = 0; k < 3; k++) label_q[k] <= '0;
    end else begin
      held_q <= held_d;
      last_q <= last_d;
      for (int k = 0; k < 3; k++) label_q[k] <= label_d[k];
    end
  end

  // --------------------------------------------------------------------------
  // Vote
  // --------------------------------------------------------------------------
  logic [LABEL_WIDTH-1:0] w_tie_label;
  logic [LABEL_WIDTH-1:0] w_vote_label;
  logic [1:0]             w_vote_count;
  logic                   w_eq01, w_eq02, w_eq12;
  logic [DATA_WIDTH-1:0]  w_result;

  // Majority decision; the configured tie source wins a three-way split.
  always_comb begin
    w_eq01 = (label_q[0] == label_q[1]);
    w_eq02 = (label_q[0] == label_q[2]);
    w_eq12 = (label_q[1] == label_q[2]);
    case (TIE_SRC)
      0:       w_tie_label = label_q[0];
      1:       w_tie_label = label_q[1];
      default: w_tie_label = label_q[2];
    endcase
    if (w_eq01 && w_eq12) begin
      w_vote_label = label_q[0];
      w_vote_count = 2'd3;
    end else if (w_eq01 || w_eq02) begin
      w_vote_label = label_q[0];
      w_vote_count = 2'd2;
    end else if (w_eq12) begin
      w_vote_label = label_q[1];
      w_vote_count = 2'd2;
    end else begin
      w_vote_label = w_tie_label;
      w_vote_count = 2'd1;
    end
  end

  // Pack result beat: label in the low bits, vote count just above, rest zero.
  always_comb begin
    w_result = '0;
    w_result[LABEL_WIDTH-1:0]           = w_vote_label;
    w_result[LABEL_WIDTH+1:LABEL_WIDTH] = w_vote_count;
  end

  // --------------------------------------------------------------------------
  // Output register and status
  // --------------------------------------------------------------------------
  // Load a new result on a vote (which may coincide with draining the old
  // one); otherwise drop valid once the consumer takes the beat.
  always_comb begin
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    sample_d   = sample_q;
    disagree_d = disagree_q;
    err_d      = err_q;
    if (w_fire) begin
      m_valid_d = 1'b1;
      m_data_d  = w_result;
      m_keep_d  = '1;
      m_last_d  = last_q[0];
      sample_d  = sample_q + 32'd1;
      if (w_vote_count != 2'd3) disagree_d = disagree_q + 32'd1;
      if (!((&last_q) || (~|last_q))) err_d = 1'b1;
    end else if (m_axis.tready) begin
      m_valid_d = 1'b0;
    end
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      sample_q   <= '0;
      disagree_q <= '0;
      err_q      <= 1'b0;
    end else begin
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      sample_q   <= sample_d;
      disagree_q <= disagree_d;
      err_q      <= err_d;
    end
  end

  assign m_axis.tvalid      = m_valid_q;
  assign m_axis.tdata       = m_data_q;
  assign m_axis.tkeep       = m_keep_q;
  assign m_axis.tlast       = m_last_q;
  assign sample_count       = sample_q;
  assign disagree_count     = disagree_q;
  assign err_tlast_mismatch = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ensemble_vote_combiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_ensemble_vote_combiner
// Description : Self-checking bench for ensemble_vote_combiner: vector table,
//               directed multi-cycle sequences and random traffic against a
//               queue-based vote model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ensemble_vote_combiner;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int LW  = 8;
  localparam int TIE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s0 ();
  ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s1 ();
  ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s2 ();
  ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m ();

  logic [31:0] sample_count, disagree_count;
  logic        err;

  ensemble_vote_combiner #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LABEL_WIDTH(LW), .TIE_SRC(TIE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_0(s0), .s_axis_1(s1), .s_axis_2(s2), .m_axis(m),
    .sample_count(sample_count), .disagree_count(disagree_count),
    .err_tlast_mismatch(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference vote: count how many labels agree with each, take the best.
  function automatic logic [DW-1:0] ref_vote(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                             input logic [LW-1:0] c);
    logic [LW-1:0] l [3];
    int n [3];
    int best;
    logic [DW-1:0] r;
    l[0] = a; l[1] = b; l[2] = c;
    for (int i = 0; i < 3; i++) begin
      n[i] = 0;
      for (int j = 0; j < 3; j++) if (l[j] == l[i]) n[i]++;
    end
    best = 0;
    for (int i = 1; i < 3; i++) if (n[i] > n[best]) best = i;
    if (n[best] == 1) best = TIE;
    r = '0;
    r[LW-1:0]     = l[best];
    r[LW+1:LW]    = 2'(n[best]);
    return r;
  endfunction

  // ---------------- model / monitor ----------------
  logic [LW:0]   q0[$], q1[$], q2[$];
  logic [DW:0]   exp_q[$];
  int            m_samples, m_disagree;
  logic          m_err;
  logic          prev_stall;
  logic [DW:0]   prev_out;
  logic [LW:0]   ma, mb, mc;
  logic [DW-1:0] mv;
  logic [DW:0]   me;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
      m_samples = 0; m_disagree = 0; m_err = 1'b0; prev_stall = 1'b0;
    end else begin
      if (s0.tvalid && s0.tready) q0.push_back({s0.tlast, s0.tdata[LW-1:0]});
      if (s1.tvalid && s1.tready) q1.push_back({s1.tlast, s1.tdata[LW-1:0]});
      if (s2.tvalid && s2.tready) q2.push_back({s2.tlast, s2.tdata[LW-1:0]});
      if (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
        ma = q0.pop_front(); mb = q1.pop_front(); mc = q2.pop_front();
        mv = ref_vote(ma[LW-1:0], mb[LW-1:0], mc[LW-1:0]);
        exp_q.push_back({ma[LW], mv});
        m_samples++;
        if (mv[LW+1:LW] != 2'd3) m_disagree++;
        if (!(ma[LW] == mb[LW] && mb[LW] == mc[LW])) m_err = 1'b1;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(m.tvalid), 64'(1'b1));
        check("stall_beat", 64'({m.tlast, m.tdata}), 64'(prev_out));
      end
      if (m.tvalid && m.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out_unexpected: got beat 0x%0h, expected no beat", m.tdata);
        end else begin
          me = exp_q.pop_front();
          check("out_beat", 64'({m.tlast, m.tdata}), 64'(me));
          check("out_keep", 64'(m.tkeep), 64'(4'hF));
        end
      end
      prev_stall = m.tvalid && !m.tready;
      prev_out   = {m.tlast, m.tdata};
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_s(input int k, input logic v, input logic [DW-1:0] d, input logic l);
    case (k)
      0:       begin s0.tvalid = v; s0.tdata = d; s0.tlast = l; end
      1:       begin s1.tvalid = v; s1.tdata = d; s1.tlast = l; end
      default: begin s2.tvalid = v; s2.tdata = d; s2.tlast = l; end
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] mk(input logic [LW-1:0] l);
    logic [DW-1:0] d;
    d = $urandom;
    d[LW-1:0] = l;
    return d;
  endfunction

  task automatic send3(input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic [LW-1:0] l2,
                       input logic t0, input logic t1, input logic t2);
    @(posedge clk); #1;
    set_s(0, 1'b1, mk(l0), t0);
    set_s(1, 1'b1, mk(l1), t1);
    set_s(2, 1'b1, mk(l2), t2);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) set_s(k, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_out(output int lat, output logic ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (m.tvalid) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL out_timeout: got no tvalid, expected tvalid within 20 cycles");
    end
  endtask

  typedef struct {
    logic [LW-1:0] l0, l1, l2;
    logic          t0, t1, t2;
    logic [DW-1:0] exp_data;
    logic          exp_last;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int          lat, n_out, out_cyc, bad, exp_dis;
  logic        ok, exp_err, busy, done;
  logic [2:0]  vld, acc;
  int          sched [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h05, 8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 32'h0000_0305, 1'b1};
    vecs[1] = '{8'h03, 8'h07, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0000_0203, 1'b0};
    vecs[2] = '{8'h01, 8'h02, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b0};
    vecs[3] = '{8'h09, 8'h09, 8'h04, 1'b1, 1'b1, 1'b1, 32'h0000_0209, 1'b1};
    vecs[4] = '{8'h04, 8'h09, 8'h09, 1'b0, 1'b0, 1'b0, 32'h0000_0209, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 32'h0000_02FF, 1'b0};
    vecs[6] = '{8'h05, 8'h06, 8'h05, 1'b1, 1'b0, 1'b1, 32'h0000_0205, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b0};
    vecs[8] = '{8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0};

    s0.tkeep = '1; s1.tkeep = '1; s2.tkeep = '1;
    for (int k = 0; k < 3; k++) set_s(k, 1'b0, '0, 1'b0);
    m.tready = 1'b1;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'({s2.tready, s1.tready, s0.tready}), 64'(3'b111));
    check("rst_m_out", 64'({m.tvalid, m.tlast, m.tkeep, m.tdata}), 64'(0));
    check("rst_status", 64'({err, disagree_count, sample_count}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(m.tvalid), 64'(1'b0));

    // ---- vector table ----
    exp_dis = 0;
    exp_err = 1'b0;
    for (int i = 0; i < NV; i++) begin
      send3(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].t0, vecs[i].t1, vecs[i].t2);
      wait_out(lat, ok);
      if (vecs[i].exp_data[LW+1:LW] != 2'd3) exp_dis++;
      if (!(vecs[i].t0 == vecs[i].t1 && vecs[i].t1 == vecs[i].t2)) exp_err = 1'b1;
      if (ok) begin
        check("tbl_data", 64'(m.tdata), 64'(vecs[i].exp_data));
        check("tbl_last", 64'(m.tlast), 64'(vecs[i].exp_last));
        check("tbl_keep", 64'(m.tkeep), 64'(4'hF));
        check("tbl_latency", 64'(lat), 64'(2));
        check("tbl_samples", 64'(sample_count), 64'(i + 1));
        check("tbl_disagree", 64'(disagree_count), 64'(exp_dis));
        check("tbl_err", 64'(err), 64'(exp_err));
      end
      @(negedge clk);
    end

    // ---- staggered arrival ----
    sched[0] = 0; sched[1] = 5; sched[2] = 9;
    n_out = 0; out_cyc = -1; bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        set_s(k, c == sched[k], mk((k == 2) ? 8'h07 : 8'h04), 1'b1);
      @(negedge clk);
      if (m.tvalid) begin
        n_out++;
        out_cyc = c;
        check("stag_data", 64'(m.tdata), 64'(32'h0000_0204));
      end
      if (c >= 1 && c <= 10 && s0.tready) bad++;
    end
    check("stag_ready0_low", 64'(bad), 64'(0));
    check("stag_n_out", 64'(n_out), 64'(1));
    check("stag_out_cycle", 64'(out_cyc), 64'(11));

    // ---- backpressure ----
    bad = 0;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk); #1;
      m.tready = (c >= 20);
      for (int k = 0; k < 3; k++) begin
        if (c == 0)      set_s(k, 1'b1, mk(8'h03), 1'b1);
        else if (c == 2) set_s(k, 1'b1, mk((k == 2) ? 8'h02 : 8'h01), 1'b0);
        else             set_s(k, 1'b0, '0, 1'b0);
      end
      @(negedge clk);
      if (c >= 4 && c <= 19)
        if (!m.tvalid || m.tdata != 32'h0000_0303 || s0.tready || s1.tready || s2.tready) bad++;
      if (c == 20) check("bp_first", 64'({m.tvalid, m.tdata}), 64'({1'b1, 32'h0000_0303}));
      if (c == 21) check("bp_second", 64'({m.tvalid, m.tdata}), 64'({1'b1, 32'h0000_0201}));
      if (c == 22) check("bp_idle", 64'(m.tvalid), 64'(1'b0));
    end
    check("bp_stall", 64'(bad), 64'(0));

    // ---- random traffic ----
    vld = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = {s2.tvalid & s2.tready, s1.tvalid & s1.tready, s0.tvalid & s0.tready};
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (!vld[k] || acc[k]) begin
          vld[k] = ($urandom_range(0, 2) != 0);
          set_s(k, vld[k], mk(8'($urandom_range(0, 3))), 1'($urandom_range(0, 1)));
        end
      end
      m.tready = ($urandom_range(0, 3) != 0);
    end

    // ---- drain: finish partial samples with filler beats ----
    m.tready = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      acc = {s2.tvalid & s2.tready, s1.tvalid & s1.tready, s0.tvalid & s0.tready};
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
        if (vld[k] && acc[k]) begin vld[k] = 1'b0; set_s(k, 1'b0, '0, 1'b0); end
      busy = (q0.size() + q1.size() + q2.size() > 0) || (|vld);
      for (int k = 0; k < 3; k++)
        if (busy && !vld[k] && qsize(k) == 0) begin vld[k] = 1'b1; set_s(k, 1'b1, mk(8'h0A), 1'b0); end
      done = !busy;
    end
    repeat (10) @(negedge clk);
    check("drain_done", 64'(done), 64'(1'b1));
    check("rand_pending", 64'(exp_q.size()), 64'(0));
    check("rand_samples", 64'(sample_count), 64'(m_samples));
    check("rand_disagree", 64'(disagree_count), 64'(m_disagree));
    check("rand_err", 64'(err), 64'(m_err));

    // ---- reset mid-operation ----
    m.tready = 1'b0;
    send3(8'h06, 8'h06, 8'h06, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    set_s(0, 1'b1, mk(8'h02), 1'b0);
    set_s(1, 1'b1, mk(8'h02), 1'b0);
    @(posedge clk); #1;
    set_s(0, 1'b0, '0, 1'b0);
    set_s(1, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("mid_pre_valid", 64'(m.tvalid), 64'(1'b1));
    check("mid_pre_ready", 64'({s2.tready, s1.tready, s0.tready}), 64'(3'b100));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'({s2.tready, s1.tready, s0.tready}), 64'(3'b111));
    check("mid_rst_out", 64'({m.tvalid, m.tlast, m.tkeep, m.tdata}), 64'(0));
    check("mid_rst_status", 64'({err, disagree_count, sample_count}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m.tready = 1'b1;
    send3(8'h07, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
    wait_out(lat, ok);
    if (ok) begin
      check("mid_after_data", 64'(m.tdata), 64'(32'h0000_0208));
      check("mid_after_samples", 64'(sample_count), 64'(1));
      check("mid_after_err", 64'(err), 64'(1'b0));
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ensemble_vote_combiner.md
# ensemble_vote_combiner

Majority-vote stage directly downstream of the three-classifier ensemble wrapper. Consumes one prediction beat from each of the three classifier AXI-Stream outputs (stream 0, stream 1, stream 2). Emits one voted class label per sample on a single AXI-Stream master, and keeps sample, disagreement and framing-error status for the host.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI-Stream data width (all streams)
- KEEP_WIDTH, 4, AXI-Stream keep width (all streams)
- LABEL_WIDTH, 8, class label bits taken from tdata[LABEL_WIDTH-1:0]; range 1..DATA_WIDTH-2
- TIE_SRC, 2, index of the stream whose label wins a three-way disagreement

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata_k  in  DATA_WIDTH  prediction from classifier k (k = 0, 1, 2)
- s_axis_tkeep_k  in  KEEP_WIDTH  ignored
- s_axis_tvalid_k  in  1  beat valid, stream k
- s_axis_tready_k  out  1  beat ready, stream k
- s_axis_tlast_k  in  1  end-of-frame marker, stream k
- m_axis_tdata  out  DATA_WIDTH  voted result
- m_axis_tkeep  out  KEEP_WIDTH  all ones whenever tvalid is high
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  tlast of the stream-0 beat
- sample_count  out  32  results emitted since reset
- disagree_count  out  32  results with vote count below 3
- err_tlast_mismatch  out  1  sticky flag: captured tlasts differed

## Operation
Per-stream hold registers:
- Each stream k has a hold register: label, tlast and a held flag.
- s_axis_tready_k = ~held_k. A handshake on stream k captures the label and tlast and sets held_k.
- Streams are accepted independently and in any order. A stream that arrives early waits until the other two arrive.

Vote (fires when held_0 & held_1 & held_2 & (~m_axis_tvalid | m_axis_tready)):
- All three labels equal: label = L0, count = 3.
- Exactly two labels equal: label = the pair value, count = 2.
- All three differ: label = L[TIE_SRC], count = 1.

When the vote fires, in the same cycle:
- The output register loads: tdata[LABEL_WIDTH-1:0] = label, tdata[LABEL_WIDTH+1:LABEL_WIDTH] = count, all higher bits 0. tlast = captured tlast_0.
- All three held flags clear.
- sample_count increments.
- disagree_count increments if count < 3.
- err_tlast_mismatch sets if the three captured tlasts are not all equal. It is cleared only by reset.

Counters wrap from 0xFFFFFFFF to 0.

Output register:
- m_axis_tvalid stays high until m_axis_tready is seen.
- tdata and tlast stay stable while tvalid is high and tready is low.

## Timing
- Reset (asynchronous assert, synchronous release):
  - s_axis_tready_k = 1, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tkeep = 0, m_axis_tlast = 0.
  - Both counters = 0, err_tlast_mismatch = 0, held flags cleared.
- Reset mid-operation discards any held beats and any pending output without emitting them.
- Latency: final input handshake in cycle N means the vote fires in cycle N+1 and m_axis_tvalid is high from cycle N+2. This assumes the output register is free.
- Throughput: at most one result every 2 cycles. tready returns high in the cycle after the vote fires.
- Output stalled (m_axis_tvalid = 1, m_axis_tready = 0) with all three held:
  - The vote waits and all s_axis_tready_k stay 0.
  - In the cycle m_axis_tready rises, the old result drains and the new one loads (back-to-back, no bubble).
- Simultaneous handshakes on all three streams in the same cycle are legal and give the same latency.
- No combinational path from any s_axis_tvalid_k or m_axis_tready to any s_axis_tready_k. s_axis_tready_k depends only on registered state.

## Test plan
- Unanimous vote:
  - Stimulus: all three streams send label 0x05 together with tlast = 1, m_axis_tready held at 1.
  - Required: m_axis_tdata = 0x00000305, tlast = 1, tkeep = 0xF, tvalid high exactly 2 cycles after the inputs. sample_count = 1, disagree_count = 0.
- Majority and tie-break:
  - Stimulus: labels (3, 7, 3), then (1, 2, 4).
  - Required: first result tdata = 0x00000203. Second result tdata = 0x00000104 (TIE_SRC = 2). disagree_count = 2.
- Staggered arrival:
  - Stimulus: stream 0 sends at cycle 0, stream 1 at cycle 5, stream 2 at cycle 9.
  - Required: s_axis_tready_0 is low during cycles 1-10. Exactly one output beat appears, at cycle 11.
- Backpressure:
  - Stimulus: m_axis_tready = 0 for 20 cycles while two complete samples arrive.
  - Required: the first result is held stable and all s_axis_tready_k are 0. After tready rises, the second result appears in the next cycle with no loss or duplication.
- tlast mismatch:
  - Stimulus: tlasts (1, 0, 1).
  - Required: err_tlast_mismatch rises and stays 1. m_axis_tlast = 1.
- Reset mid-operation:
  - Stimulus: assert rst_n low while streams 0 and 1 are held and an output is pending.
  - Required: all outputs return to their reset values immediately. The next full sample produces a correct result and sample_count = 1.
